// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit: 32-cycle iterative shift-add multiply and restoring divide,
// with MTHI/MTLO write strobes honoured whenever no operation is running.
module hilo_muldiv (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic        writeHi,
  input  logic        writeLo,
  input  logic [31:0] writeData,
  output logic        busy,
  output logic        done,
  output logic        divByZero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_res;
  logic        neg_rem;
  logic        dz_q;
  logic [31:0] a_q;
  logic [31:0] opnd;
  logic [63:0] acc;

  logic        sgn_op;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] step;
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  // Operand magnitudes as captured on the start-accept edge
  always_comb begin
    sgn_op = ~op[0];
    mag_a  = (sgn_op && operandA[31]) ? (~operandA + 32'd1) : operandA;
    mag_b  = (sgn_op && operandB[31]) ? (~operandB + 32'd1) : operandB;
  end

  // One iteration: acc holds {partial product, multiplier} for multiply,
  // {remainder, dividend/quotient} for divide; both shift one bit per cycle.
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    div_shift = {acc[63:32], acc[31]};
    div_diff  = div_shift - {1'b0, opnd};
    step      = '0;
    if (is_div) begin
      if (!div_diff[32]) step = {div_diff[31:0], acc[30:0], 1'b1};
      else               step = {div_shift[31:0], acc[30:0], 1'b0};
    end else begin
      step = {mul_sum, acc[31:1]};
    end
  end

  // Sign correction applied to the final iteration's result
  always_comb begin
    prod   = neg_res ? (~step + 64'd1) : step;
    quo    = neg_res ? (~step[31:0] + 32'd1) : step[31:0];
    rem    = neg_rem ? (~step[63:32] + 32'd1) : step[63:32];
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (is_div) begin
      if (dz_q) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz_q    <= 1'b0;
      a_q     <= '0;
      opnd    <= '0;
      acc     <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (writeHi) hi <= writeData;
          if (writeLo) lo <= writeData;
          if (start) begin
            state   <= RUN;
            cnt     <= '0;
            is_div  <= op[1];
            neg_res <= sgn_op && (operandA[31] ^ operandB[31]);
            neg_rem <= sgn_op && op[1] && operandA[31];
            dz_q    <= op[1] && (operandB == 32'd0);
            a_q     <= operandA;
            opnd    <= mag_b;
            acc     <= {32'd0, mag_a};
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= step;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= DONE;
            hi    <= res_hi;
            lo    <= res_lo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign divByZero = (state == DONE) && dz_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized self-checking bench for hilo_muldiv against a plain-arithmetic HI/LO model.
module tb_hilo_muldiv;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        writeHi;
  logic        writeLo;
  logic [31:0] writeData;
  logic        busy;
  logic        done;
  logic        divByZero;
  logic [31:0] hi;
  logic [31:0] lo;

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  hilo_muldiv dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operandA(operandA), .operandB(operandB),
    .writeHi(writeHi), .writeLo(writeLo), .writeData(writeData),
    .busy(busy), .done(done), .divByZero(divByZero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result {hi, lo} straight from integer arithmetic
  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: return 64'(sa * sb);
      2'b01: return ua * ub;
      default: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Start an operation from IDLE/DONE, optionally with a same-edge write; run it to done.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic wh, input logic wl, input logic [31:0] wd, input bit noise);
    logic [63:0] exp;
    int unsigned cycles, bcnt;
    exp = ref_res(o, a, b);
    start = 1'b1; op = o; operandA = a; operandB = b;
    writeHi = wh; writeLo = wl; writeData = wd;
    tick();
    start = 1'b0; writeHi = 1'b0; writeLo = 1'b0;
    op = 2'($urandom); operandA = $urandom; operandB = $urandom;
    if (wh) m_hi = wd;
    if (wl) m_lo = wd;
    chk("busy_rise", 64'(busy), 64'd1);
    chk("wr_on_start", {hi, lo}, {m_hi, m_lo});
    cycles = 0;
    bcnt = 0;
    while (!done && cycles < 40) begin
      if (busy) bcnt++;
      if (noise) begin
        start = 1'($urandom); writeHi = 1'($urandom); writeLo = 1'($urandom);
        writeData = $urandom;
      end
      tick();
      cycles++;
    end
    start = 1'b0; writeHi = 1'b0; writeLo = 1'b0;
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    chk("done_seen", 64'(done), 64'd1);
    chk("latency", 64'(cycles + 1), 64'd33);
    chk("busy_cycles", 64'(bcnt), 64'd32);
    chk("busy_in_done", 64'(busy), 64'd0);
    chk("result", {hi, lo}, exp);
    chk("divzero", 64'(divByZero), 64'(o[1] && b == 32'd0));
  endtask

  task automatic idle_cycle(input logic wh, input logic wl, input logic [31:0] wd);
    writeHi = wh; writeLo = wl; writeData = wd; start = 1'b0;
    tick();
    writeHi = 1'b0; writeLo = 1'b0;
    if (wh) m_hi = wd;
    if (wl) m_lo = wd;
    chk("idle_done", {62'd0, done, divByZero}, 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_hilo", {hi, lo}, {m_hi, m_lo});
  endtask

  initial begin
    int unsigned seen;
    reset = 1'b1; start = 1'b0; op = '0; operandA = '0; operandB = '0;
    writeHi = 1'b0; writeLo = 1'b0; writeData = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_flags", {61'd0, busy, done, divByZero}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);

    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, '0, 1'b0);
    chk("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
    idle_cycle(1'b0, 1'b0, '0);
    issue(2'b00, 32'hFFFFFFFD, 32'h00000007, 1'b0, 1'b0, '0, 1'b0);
    chk("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    idle_cycle(1'b0, 1'b0, '0);
    issue(2'b10, 32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0, '0, 1'b0);
    chk("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    idle_cycle(1'b0, 1'b0, '0);
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, '0, 1'b0);
    chk("div_ovf", {hi, lo}, 64'h00000000_80000000);
    chk("div_ovf_dz", 64'(divByZero), 64'd0);
    idle_cycle(1'b0, 1'b0, '0);
    issue(2'b11, 32'h00000005, 32'h0, 1'b0, 1'b0, '0, 1'b0);
    chk("divu_zero", {31'd0, divByZero, hi, lo}, {31'd0, 1'b1, 64'h00000005_FFFFFFFF});
    idle_cycle(1'b0, 1'b0, '0);

    // Abandoned operation: ignored start/write mid-run, then reset at RUN cycle 10
    start = 1'b1; op = 2'b01; operandA = 32'd3; operandB = 32'd4;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; writeHi = 1'b1; writeData = 32'hAAAA5555;
    tick();
    start = 1'b0; writeHi = 1'b0;
    chk("run_ignore_wr", {hi, lo}, {m_hi, m_lo});
    chk("run_ignore_busy", 64'(busy), 64'd1);
    repeat (4) tick();
    reset = 1'b1; start = 1'b1; writeHi = 1'b1; writeLo = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0; writeHi = 1'b0; writeLo = 1'b0;
    m_hi = '0; m_lo = '0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) seen++;
      tick();
    end
    chk("abort_no_done", 64'(seen), 64'd0);

    idle_cycle(1'b1, 1'b1, 32'h12345678);
    chk("mthi_mtlo", {hi, lo}, 64'h12345678_12345678);
    issue(2'b11, 32'd9, 32'd4, 1'b0, 1'b0, '0, 1'b0);
    chk("divu_9_4", {hi, lo}, {32'd1, 32'd2});
    issue(2'b01, 32'd2, 32'd3, 1'b0, 1'b0, '0, 1'b0);
    chk("b2b_multu", {hi, lo}, {32'd0, 32'd6});
    idle_cycle(1'b0, 1'b0, '0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(3) == 0) a = 32'h80000000;
      if ($urandom_range(5) == 0) b = 32'hFFFFFFFF;
      issue(2'($urandom), a, b, 1'($urandom), 1'($urandom), $urandom, 1'b1);
      if ($urandom_range(1) == 0) idle_cycle(1'($urandom), 1'($urandom), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 32 bits.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port list:
- clock  input  1  – sole clock; all state updates on the rising edge.
- reset  input  1  – synchronous, active-high.
- start  input  1  – request a new operation.
- op  input  2  – operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- operandA  input  32  – rs value, taken from register-file read1.
- operandB  input  32  – rt value, taken from register-file read2.
- writeHi  input  1  – MTHI strobe.
- writeLo  input  1  – MTLO strobe.
- writeData  input  32  – MTHI/MTLO data, taken from register-file read1.
- busy  output  1  – operation in progress.
- done  output  1  – one-cycle completion pulse.
- divByZero  output  1  – one-cycle pulse, coincident with done.
- hi  output  32  – HI register; consumed by MFHI for register-file write-back.
- lo  output  32  – LO register; consumed by MFLO for register-file write-back.

Function
REQ-004 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE after 32 iteration cycles.
- DONE -> RUN if start=1, otherwise DONE -> IDLE.
REQ-005 start SHALL be sampled only in IDLE and DONE; start, writeHi and writeLo SHALL be ignored in RUN.
REQ-006 op, operandA and operandB SHALL be captured on the edge that accepts start; later changes on these inputs SHALL NOT affect the result.
REQ-007 busy SHALL be 1 exactly in RUN, i.e. for 32 cycles beginning the cycle after start is accepted.
REQ-008 hi/lo SHALL be loaded on the edge leaving RUN.
- done=1 for exactly the following cycle (the DONE state).
- Start-accept edge to done high is 33 cycles.
REQ-009 Multiply SHALL be iterative shift-add over 32 cycles producing a 64-bit product: hi = product[63:32], lo = product[31:0].
REQ-010 MULT SHALL multiply operand magnitudes and negate the 64-bit product when the operand signs differ; MULTU SHALL treat both operands as unsigned.
REQ-011 Divide SHALL be restoring division, one quotient bit per cycle over 32 cycles: lo = quotient, hi = remainder.
REQ-012 DIV SHALL divide magnitudes, then apply signs:
- quotient is negative iff sign(A) xor sign(B);
- remainder takes the sign of A.
REQ-013 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000, with no error flag.
REQ-014 Division by zero (DIV or DIVU with operandB=0) SHALL still take 33 cycles and give hi=operandA, lo=0xFFFFFFFF, divByZero=1 in the done cycle.
REQ-015 In IDLE or DONE, writeHi SHALL load hi=writeData and writeLo SHALL load lo=writeData on the next edge; both may be asserted together.
REQ-016 If writeHi/writeLo and start are accepted on the same edge, the write SHALL take effect, and the operation result SHALL later overwrite hi/lo.
REQ-017 hi/lo SHALL hold their values at all times except on the edges defined in REQ-008 and REQ-015.
REQ-018 Back-to-back operation: start accepted in DONE SHALL enter RUN with no idle cycle, and busy SHALL rise on the next cycle.

Reset
REQ-019 On any edge with reset=1, regardless of state, the block SHALL enter IDLE with hi=0, lo=0, busy=0, done=0, divByZero=0.
REQ-020 Reset SHALL override start, writeHi and writeLo in the same cycle.
REQ-021 Reset SHALL abandon any in-flight operation without updating hi/lo beyond the zeroing in REQ-019.

Verification
REQ-022 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 32 cycles.
REQ-023 MULT 0xFFFFFFFD (-3) x 0x00000007 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-024 DIV 0xFFFFFFF9 (-7) / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-025 DIVU 0x00000005 / 0 -> hi=0x00000005, lo=0xFFFFFFFF, divByZero=1 for one cycle with done.
REQ-026 Start MULTU 3x4; at RUN cycle 5 pulse start and writeHi=0xAAAA5555 (both ignored). At RUN cycle 10 assert reset -> next cycle busy=0, hi=lo=0; no done pulse follows.
REQ-027 In IDLE, writeHi=1 and writeLo=1 with writeData=0x12345678 -> hi=lo=0x12345678. Then start DIVU 9/4, and assert start again in DONE with MULTU 2x3:
- first done: hi=1, lo=2;
- busy re-asserts the cycle after DONE;
- second done 33 cycles later: hi=0, lo=6.
